// File: rtl/mem_mbuf_pkg.sv
// rtl/mem_mbuf_pkg.sv - shared sizing helpers and ring-index arithmetic
package mem_mbuf_pkg;

    // Buffer index width; a two-entry ring still gets one bit.
    function automatic int buf_bit_f(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Occupancy counter width; must hold the value n itself.
    function automatic int cnt_bit_f(input int n);
        return $clog2(n + 1);
    endfunction

    // Ring increment by compare-and-clear so non-power-of-2 rings wrap correctly.
    function automatic int mod_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mem_mbuf_if.sv
// rtl/mem_mbuf_if.sv - producer/consumer handshake bundle for the multi-buffer RAM
interface mem_mbuf_if #(
    parameter int DATA_BIT = 64,
    parameter int ADDR_BIT = 10,
    parameter int BUF_BIT  = 2,
    parameter int CNT_BIT  = 2
);
    logic [ADDR_BIT-1:0] waddr;
    logic                wen;
    logic [DATA_BIT-1:0] wdata;
    logic                wr_commit;
    logic                wr_ready;
    logic [BUF_BIT-1:0]  wr_buf_idx;
    logic [ADDR_BIT-1:0] raddr;
    logic                ren;
    logic [DATA_BIT-1:0] rdata;
    logic                rdata_vld;
    logic                rd_release;
    logic                rd_valid;
    logic [BUF_BIT-1:0]  rd_buf_idx;
    logic [CNT_BIT-1:0]  fill_cnt;
    logic                err_ovf;
    logic                err_udf;

    modport master (
        output waddr, wen, wdata, wr_commit, raddr, ren, rd_release,
        input  wr_ready, wr_buf_idx, rdata, rdata_vld, rd_valid, rd_buf_idx,
               fill_cnt, err_ovf, err_udf
    );

    modport slave (
        input  waddr, wen, wdata, wr_commit, raddr, ren, rd_release,
        output wr_ready, wr_buf_idx, rdata, rdata_vld, rd_valid, rd_buf_idx,
               fill_cnt, err_ovf, err_udf
    );
endinterface

// File: rtl/mem_mbuf_ctrl.sv
// rtl/mem_mbuf_ctrl.sv - ring pointers, occupancy and handshake error tracking
module mem_mbuf_ctrl
    import mem_mbuf_pkg::*;
#(
    parameter int NUM_BUF = 3,
    parameter int BUF_BIT = buf_bit_f(NUM_BUF),
    parameter int CNT_BIT = cnt_bit_f(NUM_BUF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_commit,
    input  logic               i_rd_release,
    output logic [BUF_BIT-1:0] o_wr_ptr,
    output logic [BUF_BIT-1:0] o_rd_ptr,
    output logic [CNT_BIT-1:0] o_fill_cnt,
    output logic               o_wr_ready,
    output logic               o_rd_valid,
    output logic               o_err_ovf,
    output logic               o_err_udf
);
    localparam logic [CNT_BIT-1:0] FULL_CNT = CNT_BIT'(NUM_BUF);

    logic [BUF_BIT-1:0] r_wr_ptr;
    logic [BUF_BIT-1:0] r_rd_ptr;
    logic [CNT_BIT-1:0] r_fill_cnt;
    logic               r_err_ovf;
    logic               r_err_udf;
    logic               w_wr_ready;
    logic               w_rd_valid;
    logic               w_commit_ok;
    logic               w_release_ok;
    logic [CNT_BIT-1:0] w_fill_nxt;

    // Pointers alone are ambiguous when equal; the count decides empty vs full.
    assign w_wr_ready   = (r_fill_cnt != FULL_CNT);
    assign w_rd_valid   = (r_fill_cnt != '0);
    assign w_commit_ok  = i_wr_commit && w_wr_ready;
    assign w_release_ok = i_rd_release && w_rd_valid;

    // Occupancy update; a matched commit and release leave it unchanged.
    always_comb begin
        w_fill_nxt = r_fill_cnt;
        if (w_commit_ok && !w_release_ok) begin
            w_fill_nxt = r_fill_cnt + CNT_BIT'(1);
        end else if (!w_commit_ok && w_release_ok) begin
            w_fill_nxt = r_fill_cnt - CNT_BIT'(1);
        end
    end

    // Ring state and sticky protocol-error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill_cnt <= '0;
            r_err_ovf  <= 1'b0;
            r_err_udf  <= 1'b0;
        end else begin
            if (w_commit_ok) begin
                r_wr_ptr <= BUF_BIT'(mod_inc(int'(r_wr_ptr), NUM_BUF));
            end
            if (w_release_ok) begin
                r_rd_ptr <= BUF_BIT'(mod_inc(int'(r_rd_ptr), NUM_BUF));
            end
            r_fill_cnt <= w_fill_nxt;
            if (i_wr_commit && !w_wr_ready) begin
                r_err_ovf <= 1'b1;
            end
            if (i_rd_release && !w_rd_valid) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    assign o_wr_ptr   = r_wr_ptr;
    assign o_rd_ptr   = r_rd_ptr;
    assign o_fill_cnt = r_fill_cnt;
    assign o_wr_ready = w_wr_ready;
    assign o_rd_valid = w_rd_valid;
    assign o_err_ovf  = r_err_ovf;
    assign o_err_udf  = r_err_udf;
endmodule

// File: rtl/mem_mbuf_spram.sv
// rtl/mem_mbuf_spram.sv - single-port RAM bank with optional byte write enables
module mem_mbuf_spram #(
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 1024,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int BWE      = 0,
    parameter int WBE_BIT  = (DATA_BIT + 7) / 8
) (
    input  logic                clk,
    input  logic                i_wen,
    input  logic                i_ren,
    input  logic [ADDR_BIT-1:0] i_addr,
    input  logic [DATA_BIT-1:0] i_wdata,
    input  logic [WBE_BIT-1:0]  i_wbe,
    output logic [DATA_BIT-1:0] o_rdata
);
    logic [DATA_BIT-1:0] r_mem [DEPTH];
    logic [DATA_BIT-1:0] r_rdata;
    logic [DATA_BIT-1:0] w_mask;

    // Bit write mask: full word when byte enables are disabled.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < DATA_BIT; b++) begin
            w_mask[b] = (BWE == 0) || i_wbe[b / 8];
        end
    end

    // Storage and registered read port; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
        end
        if (i_ren) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_mbuf.sv
// rtl/mem_mbuf.sv - N-way multi-buffer RAM ring between one producer and one consumer
module mem_mbuf
    import mem_mbuf_pkg::*;
#(
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 1024,
    parameter int NUM_BUF  = 3,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int BUF_BIT  = buf_bit_f(NUM_BUF),
    parameter int CNT_BIT  = cnt_bit_f(NUM_BUF)
) (
    input logic       clk,
    input logic       rst_n,
    mem_mbuf_if.slave bus
);
    logic [BUF_BIT-1:0]  w_wr_ptr;
    logic [BUF_BIT-1:0]  w_rd_ptr;
    logic [CNT_BIT-1:0]  w_fill_cnt;
    logic                w_wr_ready;
    logic                w_rd_valid;
    logic                w_err_ovf;
    logic                w_err_udf;
    logic                w_rd_accept;
    logic [DATA_BIT-1:0] w_bank_rdata [NUM_BUF];
    logic [DATA_BIT-1:0] w_rdata;
    logic                r_rdata_vld;
    logic [BUF_BIT-1:0]  r_rd_idx;

    mem_mbuf_ctrl #(
        .NUM_BUF (NUM_BUF),
        .BUF_BIT (BUF_BIT),
        .CNT_BIT (CNT_BIT)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_commit  (bus.wr_commit),
        .i_rd_release (bus.rd_release),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_fill_cnt   (w_fill_cnt),
        .o_wr_ready   (w_wr_ready),
        .o_rd_valid   (w_rd_valid),
        .o_err_ovf    (w_err_ovf),
        .o_err_udf    (w_err_udf)
    );

    assign w_rd_accept = bus.ren && w_rd_valid;

    // Producer and consumer never own the same bank at once, so each bank
    // serves at most one side per cycle and its single port is enough.
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_bank
        logic w_wsel;
        logic w_rsel;

        assign w_wsel = w_wr_ready && (w_wr_ptr == BUF_BIT'(gi));
        assign w_rsel = w_rd_accept && (w_rd_ptr == BUF_BIT'(gi));

        mem_mbuf_spram #(
            .DATA_BIT (DATA_BIT),
            .DEPTH    (DEPTH),
            .ADDR_BIT (ADDR_BIT),
            .BWE      (0)
        ) u_bank (
            .clk     (clk),
            .i_wen   (bus.wen && w_wsel),
            .i_ren   (w_rsel),
            .i_addr  (w_wsel ? bus.waddr : bus.raddr),
            .i_wdata (bus.wdata),
            .i_wbe   ('1),
            .o_rdata (w_bank_rdata[gi])
        );
    end

    // Remember which bank a read came from; the consumer may release it in
    // the same cycle, so the live pointer cannot select the returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_vld <= 1'b0;
            r_rd_idx    <= '0;
        end else begin
            r_rdata_vld <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_idx <= w_rd_ptr;
            end
        end
    end

    // Return-data mux, forced to zero whenever no read is completing.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (r_rdata_vld && (r_rd_idx == BUF_BIT'(i))) begin
                w_rdata = w_bank_rdata[i];
            end
        end
    end

    assign bus.wr_ready   = w_wr_ready;
    assign bus.wr_buf_idx = w_wr_ptr;
    assign bus.rd_valid   = w_rd_valid;
    assign bus.rd_buf_idx = w_rd_ptr;
    assign bus.fill_cnt   = w_fill_cnt;
    assign bus.err_ovf    = w_err_ovf;
    assign bus.err_udf    = w_err_udf;
    assign bus.rdata      = w_rdata;
    assign bus.rdata_vld  = r_rdata_vld;
endmodule
